profile_ci_multi: RTL
=====================

# profile_ci_multi

Parametrised multi-channel profiling custom-instruction unit for the OpenRISC virtual prototype, the successor to the three-counter profiler. It provides NR_COUNTERS event counters of configurable width, each with registered enable/disable state, sticky overflow flags, optional saturation and an atomic snapshot bank. Software reaches it through the standard single-cycle custom-instruction port: one instruction writes a control word and reads one counter, snapshot or status word.

## Interface
- customId, 8'h00, custom-instruction number the block responds to
- NR_COUNTERS, 4, number of counter channels (1..8)
- COUNTER_WIDTH, 32, counter width in bits (16..64)
- SATURATE, 0, 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones
- clock  input  1  system clock; the block has one clock
- reset  input  1  synchronous, active-high reset
- start  input  1  custom-instruction strobe
- ciN  input  8  custom-instruction number
- valueA  input  32  read selector
- valueB  input  32  control word
- events  input  NR_COUNTERS  per-channel count qualifier, sampled each cycle; tie bit 0 high for a cycle counter
- done  output  1  instruction complete
- result  output  32  read data

## Operation
- Selected = start & (ciN == customId). All control and reads are ignored when not selected.
- Per-channel state: enable flag en[i], counter cnt[i], shadow shd[i] and sticky overflow flag ovf[i]. Reset clears all of them.
- Control word valueB:
  - [7:0] sets the enable mask.
  - [15:8] clears the enable mask.
  - [23:16] clears the counter mask.
  - [24] snapshots all counters.
  - [31:25] are ignored.
  - Mask bits at or above NR_COUNTERS are ignored.
- Counting: each cycle, if en[i] & events[i], cnt[i] increments by 1.
- Overflow: an increment from all-ones sets ovf[i].
  - SATURATE=0: cnt[i] becomes 0.
  - SATURATE=1: cnt[i] stays at all-ones.
- Clear of channel i sets cnt[i] and ovf[i] to 0. It has priority over that cycle's increment. en[i] is unchanged.
- If the same channel's set-enable and clear-enable bits are both 1, clear-enable wins and en[i] becomes 0.
- Snapshot copies every cnt[i] into shd[i] in the same edge. It captures the pre-update value, so a simultaneous clear still snapshots the old count.
- Read selector valueA:
  - [7]=1 returns the status word {16'd0, ovf zero-extended to 8 bits, en zero-extended to 8 bits}.
  - Otherwise [2:0] is the channel index, [4]=1 selects shd instead of cnt, and [3]=1 selects word [COUNTER_WIDTH-1:32] zero-extended (high word).
  - The low word is bits [31:0]; a counter narrower than 32 bits is zero-extended.
  - The high word reads 0 when COUNTER_WIDTH ≤ 32.
  - An index ≥ NR_COUNTERS reads 0.
- Reads return the register values before this cycle's clock edge. Control and read in one instruction therefore return the old value.
- When not selected, result is 32'd0 and done is 0.
- Reading a 64-bit counter coherently: software issues a snapshot, then reads shd low and high words.

## Timing
- done and result are combinational from start, ciN and valueA. done is high in the same cycle as a selected start (zero-wait custom instruction).
- Control effects (en, clear, snapshot) appear at the first rising edge with start high. They are visible to a read in the next instruction.
- Enable latency: with set-enable at edge k, the first counted event is the one sampled at edge k+1.
- A held start counts as one instruction per cycle. Control is applied on every cycle start stays high.
- Reset mid-count: at the edge where reset is high, all state goes to 0 and that cycle's control and events are discarded.
- Reset values: done=0 and result=0, given start is low during reset. All en, cnt, shd and ovf are 0.
- Stalls: the block does not stall the processor. The events inputs are sampled regardless of start.

## Test plan
- Reset, then enable channel 0 (valueB=32'h1) with events[0]=1 for 100 cycles, then read valueA=0 -> result=100 (±1 per the enable-latency rule). The status read (valueA=32'h80) returns 32'h0001.
- Simultaneous valueB=32'h0001_0101 on a running channel 0 -> en[0]=0 next cycle and cnt[0]=0. The snapshot is not taken because [24]=0. A further 50 cycles leave cnt[0] at 0.
- COUNTER_WIDTH=16, SATURATE=0: preload to 16'hFFFE by counting, then 3 events -> cnt=1 and the status ovf bit0=1. A clear (valueB=32'h10000) -> cnt=0 and ovf=0.
- SATURATE=1, same stimulus -> cnt holds at 16'hFFFF and ovf=1.
- COUNTER_WIDTH=64, snapshot plus clear in one instruction (valueB=32'h0101_0000) at count 1234 -> shd low read (valueA=32'h10)=1234, shd high read (valueA=32'h18)=0, live cnt read=0. Reading index 7 with NR_COUNTERS=4 returns 0.
- Wrong ciN (customId+1) with start=1 and any valueB -> done=0, result=0, and no state change.

Source files
------------

// File: rtl/profile_ci_multi_if.sv
// rtl/profile_ci_multi_if.sv - single-cycle custom-instruction port between processor and profiler
interface profile_ci_multi_if;
   logic        start;
   logic [7:0]  ciN;
   logic [31:0] valueA;
   logic [31:0] valueB;
   logic        done;
   logic [31:0] result;

   modport master (output start, ciN, valueA, valueB, input done, result);
   modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/profile_ci_multi.sv
// rtl/profile_ci_multi.sv - multi-channel event counters with sticky overflow and snapshot bank
module profile_ci_multi #(
   parameter logic [7:0] customId      = 8'h00,
   parameter int         NR_COUNTERS   = 4,
   parameter int         COUNTER_WIDTH = 32,
   parameter bit         SATURATE      = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NR_COUNTERS-1:0] events,
   profile_ci_multi_if.slave      ci
);
   localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

   logic [COUNTER_WIDTH-1:0] r_cnt [NR_COUNTERS];
   logic [COUNTER_WIDTH-1:0] r_shd [NR_COUNTERS];
   logic [NR_COUNTERS-1:0]   r_en;
   logic [NR_COUNTERS-1:0]   r_ovf;

   logic                     w_sel;
   logic                     w_snap;
   logic [NR_COUNTERS-1:0]   w_set_en;
   logic [NR_COUNTERS-1:0]   w_clr_en;
   logic [NR_COUNTERS-1:0]   w_clr_cnt;
   logic [63:0]              w_cnt_x [8];
   logic [63:0]              w_shd_x [8];
   logic [63:0]              w_word;
   logic [31:0]              w_rd;
   logic [31:0]              w_status;
   logic                     w_unused;

   assign w_sel     = ci.start && (ci.ciN == customId);
   assign w_set_en  = ci.valueB[NR_COUNTERS-1:0];
   assign w_clr_en  = ci.valueB[8 +: NR_COUNTERS];
   assign w_clr_cnt = ci.valueB[16 +: NR_COUNTERS];
   assign w_snap    = ci.valueB[24];
   assign w_unused  = ^{ci.valueA, ci.valueB};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_en  <= '0;
         r_ovf <= '0;
         for (int i = 0; i < NR_COUNTERS; i++) begin
            r_cnt[i] <= '0;
            r_shd[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NR_COUNTERS; i++) begin
            // snapshot takes the pre-edge count, so a same-cycle clear does not affect it
            if (w_sel && w_snap)
               r_shd[i] <= r_cnt[i];

            if (w_sel && w_clr_cnt[i]) begin
               r_cnt[i] <= '0;
               r_ovf[i] <= 1'b0;
            end else if (r_en[i] && events[i]) begin
               if (&r_cnt[i]) begin
                  r_ovf[i] <= 1'b1;
                  r_cnt[i] <= SATURATE ? r_cnt[i] : '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + ONE;
               end
            end

            if (w_sel) begin
               if (w_clr_en[i])
                  r_en[i] <= 1'b0;
               else if (w_set_en[i])
                  r_en[i] <= 1'b1;
            end
         end
      end
   end

   // pad to 8 channels of 64 bits so absent indices and absent high words read as zero
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_cnt_x[i] = '0;
         w_shd_x[i] = '0;
      end
      for (int i = 0; i < NR_COUNTERS; i++) begin
         w_cnt_x[i] = 64'(r_cnt[i]);
         w_shd_x[i] = 64'(r_shd[i]);
      end
   end

   assign w_word   = ci.valueA[4] ? w_shd_x[ci.valueA[2:0]] : w_cnt_x[ci.valueA[2:0]];
   assign w_rd     = ci.valueA[3] ? w_word[63:32] : w_word[31:0];
   assign w_status = {16'd0, 8'(r_ovf), 8'(r_en)};

   assign ci.done   = w_sel;
   assign ci.result = w_sel ? (ci.valueA[7] ? w_status : w_rd) : 32'd0;
endmodule
